md_issue_ctrl: RTL

EX-stage issue and interlock controller placed directly upstream of the multiply/divide unit. Decodes the EX-stage instruction and drives the unit's start strobe, operation code and operands. Tracks the unit's fixed latency with its own countdown, so the one-cycle gap between start and the unit's `Busy` is covered. Raises a pipeline stall whenever a HI/LO-touching instruction reaches EX while an operation is outstanding.

---
 rtl/md_pkg.sv | 48 ++++
 rtl/md_decode.sv | 42 ++++
 rtl/md_issue_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the EX-stage multiply/divide issue controller:
// instruction fields, unit operation codes, HI/LO read selects and FSM states.
package md_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MADD  = 6'b000000;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101,
        MD_MADD  = 3'b110,
        MD_NONE  = 3'b111
    } md_ctr_e;

    typedef enum logic [1:0] {
        MF_NONE = 2'b00,
        MF_HI   = 2'b01,
        MF_LO   = 2'b10
    } mf_sel_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } md_state_e;

    typedef struct packed {
        logic    md_instr;
        logic    start;
        md_ctr_e ctr;
        mf_sel_e mf_sel;
        logic    lat_div;
    } md_dec_t;

endpackage

// File: rtl/md_decode.sv
// Pure decode of an EX-stage instruction into multiply/divide control fields.
module md_decode
    import md_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output md_dec_t    dec_o
);

    // NOTE: every field gets a default before the case so no latch is inferred.
    always_comb begin
        dec_o.md_instr = 1'b0;
        dec_o.start    = 1'b0;
        dec_o.ctr      = MD_NONE;
        dec_o.mf_sel   = MF_NONE;
        dec_o.lat_div  = 1'b0;
        if (opcode_i == OP_SPECIAL) begin
            case (funct_i)
                FN_MULT:  begin dec_o.md_instr = 1'b1; dec_o.start = 1'b1; dec_o.ctr = MD_MULT;  end
                FN_MULTU: begin dec_o.md_instr = 1'b1; dec_o.start = 1'b1; dec_o.ctr = MD_MULTU; end
                FN_DIV: begin
                    dec_o.md_instr = 1'b1; dec_o.start = 1'b1; dec_o.ctr = MD_DIV;
                    dec_o.lat_div  = 1'b1;
                end
                FN_DIVU: begin
                    dec_o.md_instr = 1'b1; dec_o.start = 1'b1; dec_o.ctr = MD_DIVU;
                    dec_o.lat_div  = 1'b1;
                end
                FN_MTHI:  begin dec_o.md_instr = 1'b1; dec_o.ctr = MD_MTHI; end
                FN_MTLO:  begin dec_o.md_instr = 1'b1; dec_o.ctr = MD_MTLO; end
                FN_MFHI:  begin dec_o.md_instr = 1'b1; dec_o.mf_sel = MF_HI; end
                FN_MFLO:  begin dec_o.md_instr = 1'b1; dec_o.mf_sel = MF_LO; end
                default:  ;
            endcase
        end else if (opcode_i == OP_SPECIAL2 && funct_i == FN_MADD) begin
            dec_o.md_instr = 1'b1;
            dec_o.start    = 1'b1;
            dec_o.ctr      = MD_MADD;
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// EX-stage issue/interlock for the multiply/divide unit: issues ops, tracks
// the unit's fixed latency with a local countdown and stalls HI/LO users.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int LAT_MUL = 5,
    parameter int LAT_DIV = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_instr,
    input  logic [31:0] ex_rs,
    input  logic [31:0] ex_rt,
    input  logic        ex_flush,
    input  logic        md_busy,
    output logic        md_start,
    output logic [2:0]  md_ctr,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic [1:0]  mf_sel,
    output logic        stall,
    output logic [31:0] stall_cnt
);

    localparam logic [3:0] CNT_MUL = 4'(LAT_MUL - 2);
    localparam logic [3:0] CNT_DIV = 4'(LAT_DIV - 2);

    md_dec_t     dec;
    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        md_instr, busy_int, issue;
    logic        unused_instr_bits;

    md_decode u_decode (
        .opcode_i (ex_instr[31:26]),
        .funct_i  (ex_instr[5:0]),
        .dec_o    (dec)
    );

    assign unused_instr_bits = ^ex_instr[25:6];

    // RUN covers the cycle after start, before the unit raises its own Busy.
    assign md_instr  = ex_valid & dec.md_instr;
    assign busy_int  = (state_q == ST_RUN) | md_busy;
    assign stall     = md_instr & busy_int & ~ex_flush;
    assign issue     = md_instr & ~stall & ~ex_flush;
    assign md_start  = issue & dec.start;
    assign md_ctr    = issue ? dec.ctr : MD_NONE;
    assign mf_sel    = issue ? dec.mf_sel : MF_NONE;
    assign md_a      = ex_rs;
    assign md_b      = ex_rt;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    state_d = ST_RUN;
                    cnt_d   = dec.lat_div ? CNT_DIV : CNT_MUL;
                end
            end
            ST_RUN: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
